// File: rtl/hazard_controller_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
// Holds the multiply/divide latencies, the "operand not read" Tuse code and the op encodings.
package hazard_controller_pkg;

    localparam int unsigned MdMultCycles = 5;
    localparam int unsigned MdDivCycles  = 10;
    localparam int unsigned MdCntWidth   = 4;

    localparam logic [1:0] TuseNone = 2'd3;

    typedef enum logic [1:0] {
        MdOpMult  = 2'b00,
        MdOpMultu = 2'b01,
        MdOpDiv   = 2'b10,
        MdOpDivu  = 2'b11
    } md_op_e;

    // A source operand must wait if a younger-than-ready producer in E or M targets it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        return (src != 5'd0) &&
               (((src == e_wa) && (e_tnew > tuse)) ||
                ((src == m_wa) && (m_tnew > tuse)));
    endfunction

endpackage

// File: rtl/hazard_controller_md_busy_counter.sv
// Multiply/divide busy counter: loads the op latency on issue, then counts down to idle.
// An issue while the counter is already running is dropped.
module md_busy_counter
    import hazard_controller_pkg::*;
#(
    parameter int unsigned MultCycles = MdMultCycles,
    parameter int unsigned DivCycles  = MdDivCycles
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] op_i,
    output logic       busy_o
);

    logic [MdCntWidth-1:0] md_cnt_d, md_cnt_q;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (start_i && (md_cnt_q == '0)) begin
            // op bit 1 selects the divide family
            md_cnt_d = op_i[1] ? MdCntWidth'(DivCycles) : MdCntWidth'(MultCycles);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_controller.sv
// D-stage stall decision for the five-stage core: data hazards against E/M plus
// multiply/divide occupancy, with a free-running count of stalled cycles.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MdMultCycles,
    parameter int unsigned DIV_CYCLES  = MdDivCycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic [1:0]  E_md_op,
    output logic        pc_en,
    output logic        d_en,
    output logic        e_clr,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    logic        rs_stall, rt_stall, md_stall, stall;
    logic [31:0] stall_cycles_d, stall_cycles_q;

    md_busy_counter #(
        .MultCycles (MULT_CYCLES),
        .DivCycles  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (E_md_start),
        .op_i    (E_md_op),
        .busy_o  (md_busy)
    );

    always_comb begin
        rs_stall = src_hazard(D_rs, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
        rt_stall = src_hazard(D_rt, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
        // An md op issuing in E this cycle already occupies the unit for D.
        md_stall = D_is_md && (md_busy || E_md_start);
        stall    = rs_stall || rt_stall || md_stall;

        pc_en = ~stall;
        d_en  = ~stall;
        e_clr = stall;

        stall_cycles_d = stall ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
